// File: rtl/mp3_i2c_pkg.sv
// Shared definitions for the codec-control I2C target.
//   i2c_tgt_state_t : target FSM states
//   I2C_RW_WRITE/READ : R/W bit values in the address byte
//   CODEC_DEV_ADDR  : default 7-bit codec address
//   is_target_write : true when an address byte selects this target for writing
package mp3_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_BYTE0,
    ST_ACK0,
    ST_BYTE1,
    ST_ACK1,
    ST_IGNORE
  } i2c_tgt_state_t;

  localparam logic       I2C_RW_WRITE   = 1'b0;
  localparam logic       I2C_RW_READ    = 1'b1;
  localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;

  function automatic logic is_target_write(input logic [7:0] addr_byte,
                                           input logic [6:0] dev_addr);
    return addr_byte == {dev_addr, I2C_RW_WRITE};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser + glitch filter for one I2C line.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (filtered level presets to 1)
//   line_in  in   raw pad level
//   level    out  filtered level
//   rise     out  one-cycle pulse when the filtered level goes 0->1
//   fall     out  one-cycle pulse when the filtered level goes 1->0
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_out;

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // Synchroniser stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], line_in};
    end
  end

  // Filter stage: a new level is accepted once FILTER_LEN consecutive
  // synchronised samples disagree with the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync_out;
        rise  <= sync_out;
        fall  <= ~sync_out;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_codec_target.sv
// Write-only I2C target decoding WM8731-style 2-byte register writes.
//   clk_clk        in   system clock (>= 20x SCL)
//   reset_reset_n  in   asynchronous active-low reset
//   i2c_scl_in     in   raw SCL pad level
//   i2c_sda_in     in   raw SDA pad level
//   i2c_sda_oe     out  1 = pull SDA low (ACK only)
//   i2c_scl_oe     out  always 0, no clock stretching
//   reg_wr_valid   out  one-cycle strobe for reg_wr_addr/reg_wr_data
//   reg_wr_addr    out  codec register index
//   reg_wr_data    out  codec register value
//   bus_busy       out  1 between START and STOP
//   addr_match     out  1 from our address ACK until STOP / repeated START
module i2c_codec_target
  import mp3_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = CODEC_DEV_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       i2c_scl_in,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  output logic       i2c_scl_oe,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  output logic       bus_busy,
  output logic       addr_match
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_scl_filter (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .line_in (i2c_scl_in),
    .level   (scl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sda_filter (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .line_in (i2c_sda_in),
    .level   (sda),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign i2c_scl_oe = 1'b0;

  i2c_tgt_state_t state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           ack_on;     // second half of an ACK slot: SDA is being driven
  logic [6:0]     pend_addr;
  logic           pend_d8;

  logic           start_det, stop_det;
  logic           in_byte, byte_done;
  logic [7:0]     rx_byte;

  // Any SDA edge while SCL is high is either START or STOP; that also covers
  // mid-transfer protocol errors, which therefore abort like a STOP/START.
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  assign in_byte   = (state == ST_ADDR) || (state == ST_BYTE0) || (state == ST_BYTE1);
  assign rx_byte   = {shift[6:0], sda};
  assign byte_done = in_byte && scl_rise && (bit_cnt == 3'd7);

  // Protocol FSM, shift register and write port
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
      ack_on       <= 1'b0;
      pend_addr    <= 7'd0;
      pend_d8      <= 1'b0;
      i2c_sda_oe   <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 7'd0;
      reg_wr_data  <= 9'd0;
      bus_busy     <= 1'b0;
      addr_match   <= 1'b0;
    end else begin
      reg_wr_valid <= 1'b0;
      if (start_det) begin
        state      <= ST_ADDR;
        bit_cnt    <= 3'd0;
        shift      <= 8'd0;
        ack_on     <= 1'b0;
        i2c_sda_oe <= 1'b0;
        bus_busy   <= 1'b1;
        addr_match <= 1'b0;
      end else if (stop_det) begin
        state      <= ST_IDLE;
        bit_cnt    <= 3'd0;
        ack_on     <= 1'b0;
        i2c_sda_oe <= 1'b0;
        bus_busy   <= 1'b0;
        addr_match <= 1'b0;
      end else begin
        // bit_cnt wraps 7 -> 0 on the byte's last bit
        if (in_byte && scl_rise) begin
          shift   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          ST_ADDR: begin
            if (byte_done) begin
              state <= is_target_write(rx_byte, DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
          ST_BYTE0: begin
            if (byte_done) begin
              pend_addr <= rx_byte[7:1];
              pend_d8   <= rx_byte[0];
              state     <= ST_ACK0;
            end
          end
          ST_BYTE1: begin
            if (byte_done) begin
              reg_wr_valid <= 1'b1;
              reg_wr_addr  <= pend_addr;
              reg_wr_data  <= {pend_d8, rx_byte};
              state        <= ST_ACK1;
            end
          end
          ST_ADDR_ACK, ST_ACK0, ST_ACK1: begin
            // First SCL fall opens the ACK slot, the next one (after the
            // 9th clock) closes it. Both act one cycle after the filtered
            // fall, so SDA only moves while SCL is low.
            if (scl_fall) begin
              if (!ack_on) begin
                ack_on     <= 1'b1;
                i2c_sda_oe <= 1'b1;
              end else begin
                ack_on     <= 1'b0;
                i2c_sda_oe <= 1'b0;
                bit_cnt    <= 3'd0;
                case (state)
                  ST_ADDR_ACK: begin
                    addr_match <= 1'b1;
                    state      <= ST_BYTE0;
                  end
                  ST_ACK0: state <= ST_BYTE1;
                  default: state <= ST_BYTE0;
                endcase
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
module tb_i2c_codec_target;
  import mp3_i2c_pkg::*;

  localparam int         Q   = 10;       // quarter SCL period in clk cycles
  localparam logic [6:0] DEV = 7'h1A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_gl = 1'b0;
  logic       sda_gl = 1'b0;
  logic       scl_pad, sda_pad;
  logic       sda_oe, scl_oe, wr_valid, busy, match;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;

  assign scl_pad = m_scl ^ scl_gl;
  assign sda_pad = (m_sda & ~sda_oe) ^ sda_gl;

  always #5 clk = ~clk;

  i2c_codec_target #(
    .DEV_ADDR    (DEV),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .i2c_scl_in    (scl_pad),
    .i2c_sda_in    (sda_pad),
    .i2c_sda_oe    (sda_oe),
    .i2c_scl_oe    (scl_oe),
    .reg_wr_valid  (wr_valid),
    .reg_wr_addr   (wr_addr),
    .reg_wr_data   (wr_data),
    .bus_busy      (busy),
    .addr_match    (match)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];     // model: expected {addr7, data9} writes
  logic [15:0] dut_log[$];   // every strobe the DUT produced
  int          seg_idx = 0;  // byte index since the last START
  logic        matched = 1'b0;
  logic [7:0]  pend = 8'h00;
  logic        prev_oe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < dut_log.size()) return dut_log[i];
    return 16'hFFFF;
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    n_checks++;
    if (scl_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL scl_oe: got %b, required 0", scl_oe);
    end
    if (sda_oe !== prev_oe) begin
      n_checks++;
      if (rst_n && scl_pad !== 1'b0) begin
        n_fail++;
        $display("FAIL sda_oe_hold: sda_oe changed to %b with SCL=%b, required SCL=0", sda_oe, scl_pad);
      end
    end
    prev_oe = sda_oe;
    if (wr_valid === 1'b1) begin
      n_checks++;
      dut_log.push_back({wr_addr, wr_data});
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got addr=0x%0h data=0x%0h, required none", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_fail++;
          $display("FAIL strobe: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                   wr_addr, wr_data, e[15:9], e[8:0]);
        end
      end
    end
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
    seg_idx = 0;
    matched = 1'b0;
    check("busy_after_start", busy, 1);
    check("match_after_start", match, 0);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(2*Q);
    check("busy_after_stop", busy, 0);
    check("match_after_stop", match, 0);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wq(Q);
      m_scl = 1'b1;
      if (glitch && i == 4) begin
        wq(Q); sda_gl = 1'b1; wq(1); sda_gl = 1'b0; wq(Q-1);
      end else begin
        wq(2*Q);
      end
      m_scl = 1'b0;
      if (glitch && i == 4) begin
        wq(Q/2); scl_gl = 1'b1; wq(1); scl_gl = 1'b0; wq(Q - Q/2 - 1);
      end else begin
        wq(Q);
      end
    end
  endtask

  task automatic ack_bit(output logic acked);
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    acked = (sda_pad === 1'b0);
    wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  // Byte-level model: address byte acked only for {DEV,W}; afterwards every
  // byte is acked and consecutive pairs form {reg[6:0],d8},{d[7:0]}.
  task automatic send(input logic [7:0] b, input bit glitch);
    logic exp_ack, acked;
    if (seg_idx == 0) begin
      exp_ack = (b == {DEV, 1'b0});
      matched = exp_ack;
    end else begin
      exp_ack = matched;
      if (matched) begin
        if (seg_idx % 2 == 1) pend = b;
        else exp_q.push_back({pend[7:1], pend[0], b});
      end
    end
    write_byte(b, glitch);
    ack_bit(acked);
    check($sformatf("ack_%0d_%02h", seg_idx, b), acked, exp_ack);
    if (seg_idx == 0) check("addr_match", match, exp_ack);
    seg_idx++;
  endtask

  initial begin
    logic acked;
    int   base;

    // 1: reset holds outputs at zero while pads toggle
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m_scl = i[0]; wq(3);
      m_sda = i[1]; wq(3);
    end
    check("rst_sda_oe", sda_oe, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_match", match, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    m_scl = 1'b1; m_sda = 1'b1; wq(10);
    rst_n = 1'b1; wq(10);
    check("idle_busy", busy, 0);

    // 2: single write
    base = dut_log.size();
    bus_start();
    send(8'h34, 0); send(8'h1E, 0); send(8'h00, 0);
    bus_stop();
    check("t2_count", dut_log.size() - base, 1);
    check("t2_write", log_at(base), {7'h0F, 9'h000});
    check("t2_wr_addr_hold", wr_addr, 7'h0F);

    // 3: two pairs in one transfer
    base = dut_log.size();
    bus_start();
    send(8'h34, 0); send(8'h0D, 0); send(8'hFF, 0); send(8'h08, 0); send(8'h12, 0);
    bus_stop();
    check("t3_count", dut_log.size() - base, 2);
    check("t3_write0", log_at(base), {7'h06, 9'h1FF});
    check("t3_write1", log_at(base + 1), {7'h04, 9'h012});

    // 4: read direction and foreign address are ignored
    base = dut_log.size();
    bus_start();
    send(8'h35, 0); send(8'h1E, 0);
    bus_stop();
    bus_start();
    send(8'h30, 0); send(8'h1E, 0); send(8'h00, 0);
    bus_stop();
    check("t4_count", dut_log.size() - base, 0);

    // 5: repeated START drops the half-finished pair
    base = dut_log.size();
    bus_start();
    send(8'h34, 0); send(8'h0D, 0);
    bus_start();
    send(8'h34, 0); send(8'h08, 0); send(8'h12, 0);
    bus_stop();
    check("t5_count", dut_log.size() - base, 1);
    check("t5_write", log_at(base), {7'h04, 9'h012});

    // 6a: short glitches on both lines mid-byte
    base = dut_log.size();
    bus_start();
    send(8'h34, 0); send(8'h0D, 1); send(8'hFF, 0);
    bus_stop();
    check("t6a_count", dut_log.size() - base, 1);
    check("t6a_write", log_at(base), {7'h06, 9'h1FF});

    // 6b: reset asserted while ACK0 is being driven
    base = dut_log.size();
    bus_start();
    send(8'h34, 0);
    write_byte(8'h0D, 0);
    m_sda = 1'b1; wq(Q);
    check("t6b_ack0_driven", sda_oe, 1);
    rst_n = 1'b0; wq(1);
    check("t6b_rst_oe", sda_oe, 0);
    check("t6b_rst_busy", busy, 0);
    check("t6b_rst_match", match, 0);
    wq(3); rst_n = 1'b1;
    m_scl = 1'b1; wq(2*Q);
    m_scl = 1'b0; wq(Q);
    write_byte(8'hFF, 0);
    ack_bit(acked);
    check("t6b_no_ack_after_rst", acked, 0);
    bus_stop();
    check("t6b_count", dut_log.size() - base, 0);

    // 7: normal operation after the aborted transfer
    base = dut_log.size();
    bus_start();
    send(8'h34, 0); send(8'h1E, 0); send(8'h00, 0);
    bus_stop();
    check("t7_count", dut_log.size() - base, 1);
    check("t7_write", log_at(base), {7'h0F, 9'h000});

    wq(10);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
